// File: rtl/sound_sequencer_if.sv
// sound_sequencer_if: sound type enum plus event/output bundle for the sound sequencer.
// chomp_hold exists only when SOUND_LOOP_EN is defined.
package sound_pkg;
  typedef enum logic [1:0] {SOUND_LOADING, SOUND_GAME_PLAY, SOUND_FAIL, SOUND_WIN} sound_t;
endpackage

interface sound_sequencer_if;
  import sound_pkg::*;
  logic evt_intro;
  logic evt_chomp;
  logic evt_death;
  logic evt_win;
`ifdef SOUND_LOOP_EN
  logic chomp_hold;
`endif
  sound_t sound_type;
  logic clk_8KHZ;
  logic restart;
  logic mute;
`ifdef SOUND_LOOP_EN
  modport master (output evt_intro, evt_chomp, evt_death, evt_win, chomp_hold, input sound_type, clk_8KHZ, restart, mute);
  modport slave (input evt_intro, evt_chomp, evt_death, evt_win, chomp_hold, output sound_type, clk_8KHZ, restart, mute);
`else
  modport master (output evt_intro, evt_chomp, evt_death, evt_win, input sound_type, clk_8KHZ, restart, mute);
  modport slave (input evt_intro, evt_chomp, evt_death, evt_win, output sound_type, clk_8KHZ, restart, mute);
`endif
endinterface

// File: rtl/sound_sequencer.sv
// sound_sequencer: picks the highest-priority sound event, times its playback with an 8 kHz strobe.
// Optional SOUND_LOOP_EN: chomp_hold keeps the chomp sound looping.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int CLK_DIV = 3125,
  parameter int CHOMP_LEN = 5736,
  parameter int INTRO_LEN = 12280,
  parameter int DEATH_LEN = 33736,
  parameter int WIN_LEN = 8000
) (
  input logic clk_25MHZ,
  input logic rst,
  sound_sequencer_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0, PLAY = 1'b1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int M1 = CHOMP_LEN > INTRO_LEN ? CHOMP_LEN : INTRO_LEN;
  localparam int M2 = DEATH_LEN > WIN_LEN ? DEATH_LEN : WIN_LEN;
  localparam int MAXLEN = M1 > M2 ? M1 : M2;
  localparam int CW = MAXLEN > 1 ? $clog2(MAXLEN) : 1;
  logic [0:0] state;
  logic [DW-1:0] div;
  logic [CW-1:0] cnt, len_m1;
  sound_t ev_snd;
  logic ev_any, take, done, loop, div_end;
  function automatic logic [1:0] rank(sound_t s);
    rank = s == SOUND_FAIL ? 2'd3 : s == SOUND_LOADING ? 2'd2 : s == SOUND_WIN ? 2'd1 : 2'd0;
  endfunction
  always_comb begin
    ev_snd = bus.evt_death ? SOUND_FAIL : bus.evt_intro ? SOUND_LOADING : bus.evt_win ? SOUND_WIN : SOUND_GAME_PLAY;
    ev_any = bus.evt_death | bus.evt_intro | bus.evt_win | bus.evt_chomp;
    len_m1 = bus.sound_type == SOUND_FAIL ? CW'(DEATH_LEN - 1) :
             bus.sound_type == SOUND_LOADING ? CW'(INTRO_LEN - 1) :
             bus.sound_type == SOUND_WIN ? CW'(WIN_LEN - 1) : CW'(CHOMP_LEN - 1);
    div_end = div == DW'(CLK_DIV - 1);
    take = ev_any && (state == IDLE || rank(ev_snd) >= rank(bus.sound_type));
    done = state == PLAY && bus.clk_8KHZ && cnt == len_m1;
`ifdef SOUND_LOOP_EN
    loop = done && bus.chomp_hold && bus.sound_type == SOUND_GAME_PLAY;
`else
    loop = 1'b0;
`endif
  end
  // Playback timing runs off the registered strobe, so the divider is never disturbed by events.
  always_ff @(posedge clk_25MHZ or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      div <= '0;
      cnt <= '0;
      bus.sound_type <= SOUND_LOADING;
      bus.clk_8KHZ <= 1'b0;
      bus.restart <= 1'b0;
      bus.mute <= 1'b1;
    end else begin
      div <= div_end ? '0 : div + 1'b1;
      bus.clk_8KHZ <= div_end;
      bus.restart <= take | loop;
      if (take) begin
        state <= PLAY;
        bus.sound_type <= ev_snd;
        cnt <= '0;
        bus.mute <= 1'b0;
      end else if (loop) begin
        cnt <= '0;
      end else if (done) begin
        state <= IDLE;
        bus.mute <= 1'b1;
      end else if (state == PLAY && bus.clk_8KHZ) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: randomized and directed checks of sound_sequencer against a countdown model.
module tb_sound_sequencer;
  import sound_pkg::*;
  localparam int CLK_DIV = 4, CHOMP_LEN = 3, INTRO_LEN = 5, DEATH_LEN = 6, WIN_LEN = 2;
  logic clk_25MHZ = 0;
  logic rst = 1;
  int checks = 0, errors = 0;
  sound_sequencer_if bus();
  sound_sequencer #(.CLK_DIV(CLK_DIV), .CHOMP_LEN(CHOMP_LEN), .INTRO_LEN(INTRO_LEN),
    .DEATH_LEN(DEATH_LEN), .WIN_LEN(WIN_LEN)) dut (.clk_25MHZ(clk_25MHZ), .rst(rst), .bus(bus));
  always #5 clk_25MHZ = ~clk_25MHZ;

  // Reference: playback is a countdown of strobes left; strobes fall every CLK_DIV edges after reset.
  int e, m_left;
  bit m_play, m_restart, m_strobe, m_hold;
  sound_t m_snd;
  function automatic int prio(sound_t s);
    case (s)
      SOUND_FAIL: return 3;
      SOUND_LOADING: return 2;
      SOUND_WIN: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic int len_of(sound_t s);
    case (s)
      SOUND_FAIL: return DEATH_LEN;
      SOUND_LOADING: return INTRO_LEN;
      SOUND_WIN: return WIN_LEN;
      default: return CHOMP_LEN;
    endcase
  endfunction
  always @(posedge clk_25MHZ or posedge rst) begin
    if (rst) begin
      e = 0; m_left = 0; m_play = 0; m_restart = 0; m_strobe = 0; m_snd = SOUND_LOADING;
    end else begin
      bit any;
      sound_t s;
`ifdef SOUND_LOOP_EN
      m_hold = bus.chomp_hold;
`else
      m_hold = 0;
`endif
      any = bus.evt_death | bus.evt_intro | bus.evt_win | bus.evt_chomp;
      s = bus.evt_death ? SOUND_FAIL : bus.evt_intro ? SOUND_LOADING : bus.evt_win ? SOUND_WIN : SOUND_GAME_PLAY;
      m_restart = 0;
      if (any && (!m_play || prio(s) >= prio(m_snd))) begin
        m_play = 1; m_snd = s; m_left = len_of(s); m_restart = 1;
      end else if (m_play && m_strobe) begin
        m_left--;
        if (m_left == 0) begin
          if (m_hold && m_snd == SOUND_GAME_PLAY) begin
            m_left = len_of(m_snd); m_restart = 1;
          end else m_play = 0;
        end
      end
      e++;
      m_strobe = (e % CLK_DIV) == 0;
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk_25MHZ) begin
    chk("model sound_type", int'(bus.sound_type), int'(m_snd));
    chk("model clk_8KHZ", int'(bus.clk_8KHZ), int'(m_strobe));
    chk("model restart", int'(bus.restart), int'(m_restart));
    chk("model mute", int'(bus.mute), int'(!m_play));
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk_25MHZ);
    #1;
  endtask
  task automatic pulse(logic [3:0] ev);
    {bus.evt_death, bus.evt_intro, bus.evt_win, bus.evt_chomp} = ev;
    tick(1);
    {bus.evt_death, bus.evt_intro, bus.evt_win, bus.evt_chomp} = 4'b0;
  endtask
  task automatic wait_mute(output int strobes, output logic prev);
    bit seen = 0;
    strobes = 0; prev = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.mute) begin seen = 1; break; end
      prev = bus.clk_8KHZ;
      strobes += int'(bus.clk_8KHZ);
      tick(1);
    end
    chk("mute timeout", int'(seen), 1);
  endtask
  task automatic wait_strobes(int n);
    int s = 0;
    for (int i = 0; i < 200 && s < n; i++) begin
      s += int'(bus.clk_8KHZ);
      tick(1);
    end
    chk("strobe timeout", s, n);
  endtask

  initial begin
    int st;
    logic pv;
    {bus.evt_death, bus.evt_intro, bus.evt_win, bus.evt_chomp} = 4'b0;
`ifdef SOUND_LOOP_EN
    bus.chomp_hold = 0;
`endif
    tick(3);
    chk("reset mute", int'(bus.mute), 1);
    chk("reset restart", int'(bus.restart), 0);
    chk("reset strobe", int'(bus.clk_8KHZ), 0);
    chk("reset sound_type", int'(bus.sound_type), int'(SOUND_LOADING));
    rst = 0;
    tick(3);
    chk("no strobe edge 3", int'(bus.clk_8KHZ), 0);
    tick(1);
    chk("strobe edge 4", int'(bus.clk_8KHZ), 1);
    tick(4);
    chk("strobe edge 8", int'(bus.clk_8KHZ), 1);
    tick(4);
    chk("strobe edge 12", int'(bus.clk_8KHZ), 1);
    chk("idle mute", int'(bus.mute), 1);
    tick(2);
    pulse(4'b0001);
    chk("chomp sound_type", int'(bus.sound_type), int'(SOUND_GAME_PLAY));
    chk("chomp restart", int'(bus.restart), 1);
    chk("chomp mute", int'(bus.mute), 0);
    wait_mute(st, pv);
    chk("chomp strobes", st, 3);
    chk("chomp mute after strobe", int'(pv), 1);
    chk("chomp sound held", int'(bus.sound_type), int'(SOUND_GAME_PLAY));
    tick(1);
    pulse(4'b1001);
    chk("death wins sound_type", int'(bus.sound_type), int'(SOUND_FAIL));
    wait_mute(st, pv);
    chk("death strobes", st, 6);
    pulse(4'b1000);
    wait_strobes(2);
    pulse(4'b0100);
    chk("intro ignored restart", int'(bus.restart), 0);
    chk("intro ignored sound", int'(bus.sound_type), int'(SOUND_FAIL));
    pulse(4'b1000);
    chk("death restart", int'(bus.restart), 1);
    wait_mute(st, pv);
    chk("death restarted strobes", st, 6);
    pulse(4'b0100);
    chk("intro sound_type", int'(bus.sound_type), int'(SOUND_LOADING));
    wait_strobes(2);
    pulse(4'b0010);
    chk("win ignored", int'(bus.sound_type), int'(SOUND_LOADING));
    rst = 1;
    #1;
    chk("async rst mute", int'(bus.mute), 1);
    chk("async rst sound", int'(bus.sound_type), int'(SOUND_LOADING));
    chk("async rst restart", int'(bus.restart), 0);
    #1 rst = 0;
    tick(20);
    chk("post rst mute", int'(bus.mute), 1);
`ifdef SOUND_LOOP_EN
    begin
      int rs = 0;
      bus.chomp_hold = 1;
      pulse(4'b0001);
      for (int i = 0; i < 40; i++) begin
        rs += int'(bus.restart);
        chk("loop mute low", int'(bus.mute), 0);
        tick(1);
      end
      chk("loop restarts", int'(rs >= 3), 1);
      bus.chomp_hold = 0;
      wait_mute(st, pv);
      chk("loop stops", int'(st <= 3), 1);
    end
`endif
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ev;
      ev = ($urandom % 10 == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      {bus.evt_death, bus.evt_intro, bus.evt_win, bus.evt_chomp} = ev;
`ifdef SOUND_LOOP_EN
      if ($urandom % 50 == 0) bus.chomp_hold = ~bus.chomp_hold;
`endif
      tick(1);
    end
    {bus.evt_death, bus.evt_intro, bus.evt_win, bus.evt_chomp} = 4'b0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 3125: clk_25MHZ cycles per sample strobe (25 MHz / 8 kHz).
REQ-002 Parameter CHOMP_LEN, default 5736: chomp length in samples.
REQ-003 Parameter INTRO_LEN, default 12280: intro length in samples.
REQ-004 Parameter DEATH_LEN, default 33736: death length in samples.
REQ-005 Parameter WIN_LEN, default 8000: win length in samples.
REQ-006 clk_25MHZ  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 evt_intro  input  1  one-cycle request to play the intro sound.
REQ-009 evt_chomp  input  1  one-cycle request to play the chomp sound.
REQ-010 evt_death  input  1  one-cycle request to play the death sound.
REQ-011 evt_win  input  1  one-cycle request to play the win sound.
REQ-012 sound_type  output  sound_t  selected sound, registered.
REQ-013 clk_8KHZ  output  1  sample strobe, one cycle high every CLK_DIV cycles.
REQ-014 restart  output  1  one-cycle pulse when a playback starts; audio stage reloads sample address 0.
REQ-015 mute  output  1  high when no playback is active.

Function
REQ-016 Divider counts 0..CLK_DIV-1 and wraps; clk_8KHZ is high in the cycle the count equals CLK_DIV-1; the divider is free-running and never resynchronised by playback events.
REQ-017 FSM states: IDLE and PLAY.
REQ-018 Priority, highest first: death, intro, win, chomp; simultaneous events resolve to the highest.
REQ-019 Mapping: intro->SOUND_LOADING, chomp->SOUND_GAME_PLAY, death->SOUND_FAIL, win->SOUND_WIN.
REQ-020 In IDLE, any event moves the FSM to PLAY on the next edge, loading sound_type, clearing the sample counter, setting restart=1 for one cycle and mute=0.
REQ-021 In PLAY, an event of strictly higher priority than the current sound preempts it with the REQ-020 behaviour.
REQ-022 In PLAY, an event of equal priority restarts the current sound: counter cleared and restart pulsed.
REQ-023 In PLAY, an event of lower priority is discarded and not queued.
REQ-024 The sample counter increments on each clk_8KHZ during PLAY and is wide enough for DEATH_LEN-1.
REQ-025 When clk_8KHZ coincides with counter = LEN-1 of the current sound, the FSM enters IDLE; mute=1 on the next edge and sound_type holds its last value.
REQ-026 An event arriving in the same cycle as completion takes precedence, and the FSM stays in PLAY with the new sound per REQ-020.
REQ-027 Each output changes exactly one cycle after its cause; no combinational path from any input to any output.

Reset
REQ-028 While rst=1: FSM=IDLE, divider=0, sample counter=0, sound_type=SOUND_LOADING, clk_8KHZ=0, restart=0, mute=1.
REQ-029 Assertion of rst mid-playback aborts the playback immediately, with no completion behaviour.
REQ-030 On the first edge after rst deasserts, the divider counts from 0, so the first clk_8KHZ occurs at edge CLK_DIV.

Configuration
REQ-031 Macro SOUND_LOOP_EN, when defined, adds input chomp_hold (1 bit); at chomp completion with chomp_hold=1 the sequencer remains in PLAY, clears the counter and pulses restart.
REQ-032 Without SOUND_LOOP_EN the chomp_hold port does not exist and every completion follows REQ-025.

Verification (CLK_DIV=4, CHOMP_LEN=3, INTRO_LEN=5, DEATH_LEN=6, WIN_LEN=2)
REQ-033 Reset release with no events -> clk_8KHZ high at cycles 4, 8, 12; mute=1 throughout; restart never high.
REQ-034 evt_chomp pulse -> next cycle sound_type=SOUND_GAME_PLAY, restart=1, mute=0; mute returns to 1 one cycle after the 3rd strobe.
REQ-035 evt_chomp and evt_death in the same cycle -> sound_type=SOUND_FAIL; playback lasts 6 strobes.
REQ-036 During death playback, evt_intro -> ignored, no restart; then evt_death -> restart pulse and counter back to 0.
REQ-037 rst pulse during intro playback after the 2nd strobe -> mute=1 and sound_type=SOUND_LOADING asynchronously; no further restart.
REQ-038 With SOUND_LOOP_EN defined and chomp_hold=1 -> restart pulses after every 3 strobes and mute stays 0; dropping chomp_hold gives mute=1 after the next completion.
